// File: rtl/axicb_wr_lock_pkg.sv
// Shared types for the crossbar write-port grant lock.
package axicb_wr_lock_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} wr_lock_state_t;

  localparam int MAX_REQ_NB = 8;

endpackage

// File: rtl/axicb_onehot_mux.sv
// AND-OR select of one W-bit slice out of a packed N*W bus by a one-hot vector.
// An all-zero select yields zero; a non one-hot select ORs the chosen slices.
module axicb_onehot_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]   i_sel,
  input  logic [N*W-1:0] i_data,
  output logic [W-1:0]   o_data
);

  // OR together every slice whose select bit is set
  always_comb begin
    o_data = '0;
    for (int i = 0; i < N; i++) begin
      o_data = o_data | (i_data[i*W +: W] & {W{i_sel[i]}});
    end
  end

endmodule

// File: rtl/axicb_wr_grant_lock.sv
// Write-port grant lock: latches the arbiter's one-hot grant and holds the chosen
// slave on the master port from its AW beat through WLAST, so bursts never interleave.
module axicb_wr_grant_lock
  import axicb_wr_lock_pkg::*;
#(
  parameter int REQ_NB    = 4,
  parameter int AWCH_W    = 64,
  parameter int WCH_W     = 72,
  parameter int MAX_BEATS = 256
) (
  input  logic                     aclk,
  input  logic                     arst,
  input  logic                     srst,
  output logic [REQ_NB-1:0]        arb_req,
  output logic                     arb_en,
  input  logic [REQ_NB-1:0]        arb_grant,
  input  logic [REQ_NB-1:0]        slv_awvalid,
  output logic [REQ_NB-1:0]        slv_awready,
  input  logic [REQ_NB*AWCH_W-1:0] slv_awch,
  input  logic [REQ_NB-1:0]        slv_wvalid,
  output logic [REQ_NB-1:0]        slv_wready,
  input  logic [REQ_NB-1:0]        slv_wlast,
  input  logic [REQ_NB*WCH_W-1:0]  slv_wch,
  output logic                     mst_awvalid,
  input  logic                     mst_awready,
  output logic [AWCH_W-1:0]        mst_awch,
  output logic                     mst_wvalid,
  input  logic                     mst_wready,
  output logic                     mst_wlast,
  output logic [WCH_W-1:0]         mst_wch,
  output logic                     busy,
  output logic                     err_overrun
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;

  wr_lock_state_t    r_state, w_nxt_state;
  logic [REQ_NB-1:0] r_sel;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_err;

  logic [REQ_NB-1:0] w_grant_lo;
  logic              w_awvalid_sel, w_wvalid_sel, w_wlast_sel;
  logic              w_aw_hs, w_w_hs;

  // Lowest set bit guards against a malformed multi-hot grant
  assign w_grant_lo    = arb_grant & (~arb_grant + REQ_NB'(1));
  assign w_awvalid_sel = |(slv_awvalid & r_sel);
  assign w_wvalid_sel  = |(slv_wvalid & r_sel);
  assign w_wlast_sel   = |(slv_wlast & r_sel);
  // A sync reset in the same cycle cancels the handshake
  assign w_aw_hs = (r_state == ADDR) && w_awvalid_sel && mst_awready && !srst;
  assign w_w_hs  = (r_state == DATA) && w_wvalid_sel && mst_wready && !srst;

  assign busy        = (r_state != IDLE);
  assign err_overrun = r_err;

  axicb_onehot_mux #(.N(REQ_NB), .W(AWCH_W)) u_aw_mux (
    .i_sel  (r_sel),
    .i_data (slv_awch),
    .o_data (mst_awch)
  );

  axicb_onehot_mux #(.N(REQ_NB), .W(WCH_W)) u_w_mux (
    .i_sel  (r_sel),
    .i_data (slv_wch),
    .o_data (mst_wch)
  );

  // State register
  always_ff @(posedge aclk or posedge arst) begin
    if (arst)      r_state <= IDLE;
    else if (srst) r_state <= IDLE;
    else           r_state <= w_nxt_state;
  end

  // Next state and handshake routing; srst forces every valid/ready low
  always_comb begin
    w_nxt_state = r_state;
    arb_req     = '0;
    arb_en      = 1'b0;
    slv_awready = '0;
    slv_wready  = '0;
    mst_awvalid = 1'b0;
    mst_wvalid  = 1'b0;
    mst_wlast   = 1'b0;
    case (r_state)
      IDLE: begin
        arb_req = slv_awvalid;
        if (|arb_grant) begin
          arb_en      = 1'b1;
          w_nxt_state = ADDR;
        end
      end
      ADDR: begin
        mst_awvalid = w_awvalid_sel;
        slv_awready = r_sel & {REQ_NB{mst_awready}};
        if (w_aw_hs) w_nxt_state = DATA;
      end
      DATA: begin
        mst_wvalid = w_wvalid_sel;
        mst_wlast  = w_wlast_sel;
        slv_wready = r_sel & {REQ_NB{mst_wready}};
        if (w_w_hs && w_wlast_sel) w_nxt_state = IDLE;
      end
      default: w_nxt_state = IDLE;
    endcase
    if (srst) begin
      arb_en      = 1'b0;
      slv_awready = '0;
      slv_wready  = '0;
      mst_awvalid = 1'b0;
      mst_wvalid  = 1'b0;
    end
  end

  // Grant latch, saturating beat counter and sticky overrun flag
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      r_sel      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (srst) begin
      r_sel      <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == IDLE && |arb_grant) r_sel <= w_grant_lo;
      if (w_aw_hs)
        r_beat_cnt <= '0;
      else if (w_w_hs && r_beat_cnt != {CNT_W{1'b1}})
        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      if (w_w_hs && !w_wlast_sel && r_beat_cnt == CNT_W'(MAX_BEATS - 1))
        r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axicb_wr_grant_lock.sv
// Randomized bench: slave BFMs fed from burst queues, a round-robin arbiter stub,
// and a transaction-level model of port ownership, burst ordering and overrun.
module tb_axicb_wr_grant_lock;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int WW = 72;
  localparam int MB = 4;

  logic            aclk = 1'b0;
  logic            arst, srst;
  logic [N-1:0]    arb_req, arb_grant;
  logic            arb_en;
  logic [N-1:0]    slv_awvalid, slv_awready, slv_wvalid, slv_wready, slv_wlast;
  logic [N*AW-1:0] slv_awch;
  logic [N*WW-1:0] slv_wch;
  logic            mst_awvalid, mst_awready, mst_wvalid, mst_wready, mst_wlast;
  logic [AW-1:0]   mst_awch;
  logic [WW-1:0]   mst_wch;
  logic            busy, err_overrun;

  always #5 aclk = ~aclk;

  axicb_wr_grant_lock #(.REQ_NB(N), .AWCH_W(AW), .WCH_W(WW), .MAX_BEATS(MB)) dut (
    .aclk(aclk), .arst(arst), .srst(srst),
    .arb_req(arb_req), .arb_en(arb_en), .arb_grant(arb_grant),
    .slv_awvalid(slv_awvalid), .slv_awready(slv_awready), .slv_awch(slv_awch),
    .slv_wvalid(slv_wvalid), .slv_wready(slv_wready), .slv_wlast(slv_wlast), .slv_wch(slv_wch),
    .mst_awvalid(mst_awvalid), .mst_awready(mst_awready), .mst_awch(mst_awch),
    .mst_wvalid(mst_wvalid), .mst_wready(mst_wready), .mst_wlast(mst_wlast), .mst_wch(mst_wch),
    .busy(busy), .err_overrun(err_overrun)
  );

  // ---- round-robin arbiter stub ----
  int rr_ptr;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  always_comb arb_grant = (|arb_req) ? (N'(1) << pick(arb_req, rr_ptr)) : '0;

  always @(posedge aclk or posedge arst) begin
    if (arst)        rr_ptr <= 0;
    else if (arb_en) rr_ptr <= (pick(arb_req, rr_ptr) + 1) % N;
  end

  always @(posedge aclk) if (!arst) assert ($onehot0(arb_grant));

  // ---- checking ----
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- slave BFM state: each queued burst is just its beat count ----
  int aw_q[N][$];
  int w_q[N][$];
  int aw_seq[N], w_seq[N], w_beat[N], aw_hold[N];
  bit w_up[N];

  // knobs
  int awr_mode, wr_mode, w_prob, wr_pat_idx;
  bit do_srst;

  // model: 0 = port free, 1 = owner presents AW, 2 = owner streams W
  int ph, own, burst_beat;
  bit exp_err;

  // stats
  int n_aw_en, n_whs, st_early, err_beat, cyc;
  int aw_cyc[$], aw_own[$];

  function automatic logic [AW-1:0] awp(input int s, input int seq, input int len);
    return {16'(s), 16'(seq), 16'(len), 16'h5A5A};
  endfunction

  function automatic logic [WW-1:0] wp(input int s, input int seq, input int b);
    return {8'(s), 16'(seq), 16'(b), 32'hC0DE_0000 | 32'(b * 7 + s)};
  endfunction

  task automatic add_burst(input int s, input int len);
    aw_q[s].push_back(len);
    w_q[s].push_back(len);
  endtask

  task automatic flush();
    for (int s = 0; s < N; s++) begin
      aw_q[s].delete();
      w_q[s].delete();
      aw_seq[s] += 16;
      w_seq[s] = aw_seq[s];
      w_beat[s] = 0;
      w_up[s] = 1'b0;
      aw_hold[s] = 0;
    end
    ph = 0;
    exp_err = 1'b0;
  endtask

  function automatic bit all_idle();
    for (int s = 0; s < N; s++) if (aw_q[s].size() != 0 || w_q[s].size() != 0) return 1'b0;
    return ph == 0;
  endfunction

  // One clock: drive at negedge, evaluate 1 time unit later, advance to next negedge
  task automatic step();
    logic [N-1:0] av, wv, oh;
    bit           lst;
    for (int s = 0; s < N; s++) begin
      av[s] = (aw_q[s].size() > 0) && (aw_hold[s] == 0);
      if (!w_up[s] && w_q[s].size() > 0 && $urandom_range(99) < w_prob) w_up[s] = 1'b1;
      wv[s] = w_up[s];
      slv_awch[s*AW +: AW] = '0;
      slv_wch[s*WW +: WW]  = '0;
      slv_wlast[s]         = 1'b0;
      if (av[s]) slv_awch[s*AW +: AW] = awp(s, aw_seq[s], aw_q[s][0]);
      if (wv[s]) begin
        slv_wch[s*WW +: WW] = wp(s, w_seq[s], w_beat[s]);
        slv_wlast[s]        = (w_beat[s] + 1 == w_q[s][0]);
      end
    end
    slv_awvalid = av;
    slv_wvalid  = wv;
    mst_awready = (awr_mode == 0) ? 1'b1 : 1'($urandom_range(1));
    case (wr_mode)
      0:       mst_wready = 1'b1;
      1:       mst_wready = 1'($urandom_range(1));
      default: mst_wready = (wr_pat_idx % 4 == 0) || (wr_pat_idx % 4 == 3);
    endcase
    if (wr_mode == 2) wr_pat_idx++;
    srst = do_srst;
    #1;
    if (wv[1] && !av[1] && aw_q[1].size() > 0) st_early++;
    if (do_srst) begin
      chk("srst_awready", slv_awready, 0);
      chk("srst_wready", slv_wready, 0);
      chk("srst_awvalid", mst_awvalid, 0);
      chk("srst_wvalid", mst_wvalid, 0);
      chk("srst_arb_en", arb_en, 0);
      flush();
    end else begin
      if (arb_en) n_aw_en++;
      if (err_overrun && err_beat < 0) err_beat = n_whs;
      chk("err_overrun", err_overrun, exp_err);
      oh = N'(1) << own;
      case (ph)
        0: begin
          chk("idle_arb_req", arb_req, av);
          chk("idle_arb_en", arb_en, |av);
          chk("idle_busy", busy, 0);
          chk("idle_awready", slv_awready, 0);
          chk("idle_wready", slv_wready, 0);
          chk("idle_awvalid", mst_awvalid, 0);
          chk("idle_wvalid", mst_wvalid, 0);
          if (|av) begin
            own = pick(av, rr_ptr);
            ph  = 1;
          end
        end
        1: begin
          chk("addr_busy", busy, 1);
          chk("addr_arb_en", arb_en, 0);
          chk("addr_arb_req", arb_req, 0);
          chk("addr_awvalid", mst_awvalid, av[own]);
          if (av[own]) chk("addr_awch", mst_awch, awp(own, aw_seq[own], aw_q[own][0]));
          chk("addr_awready", slv_awready, mst_awready ? oh : '0);
          chk("addr_wready", slv_wready, 0);
          chk("addr_wvalid", mst_wvalid, 0);
          if (av[own] && mst_awready) begin
            aw_cyc.push_back(cyc);
            aw_own.push_back(own);
            void'(aw_q[own].pop_front());
            aw_seq[own]++;
            burst_beat = 0;
            ph = 2;
          end
        end
        default: begin
          chk("data_busy", busy, 1);
          chk("data_arb_en", arb_en, 0);
          chk("data_awvalid", mst_awvalid, 0);
          chk("data_awready", slv_awready, 0);
          chk("data_wvalid", mst_wvalid, wv[own]);
          chk("data_wready", slv_wready, mst_wready ? oh : '0);
          if (wv[own]) begin
            lst = (w_beat[own] + 1 == w_q[own][0]);
            chk("data_wch", mst_wch, wp(own, w_seq[own], w_beat[own]));
            chk("data_wlast", mst_wlast, lst);
            if (mst_wready) begin
              w_up[own] = 1'b0;
              burst_beat++;
              n_whs++;
              if (!lst && burst_beat >= MB) exp_err = 1'b1;
              if (lst) begin
                void'(w_q[own].pop_front());
                w_seq[own]++;
                w_beat[own] = 0;
                ph = 0;
              end else begin
                w_beat[own]++;
              end
            end
          end
        end
      endcase
    end
    for (int s = 0; s < N; s++) if (aw_hold[s] > 0 && aw_q[s].size() > 0) aw_hold[s]--;
    cyc++;
    @(negedge aclk);
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_drain_in_budget"}, n < budget, 1);
    step();
  endtask

  // Async reset asserted mid-cycle: outputs must collapse without waiting for a clock
  task automatic arst_pulse();
    arst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_err", err_overrun, 0);
    chk("arst_awvalid", mst_awvalid, 0);
    chk("arst_wvalid", mst_wvalid, 0);
    chk("arst_awready", slv_awready, 0);
    chk("arst_wready", slv_wready, 0);
    flush();
    @(negedge aclk);
    arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1; srst = 1'b0; do_srst = 1'b0;
    slv_awvalid = '0; slv_wvalid = '0; slv_wlast = '0; slv_awch = '0; slv_wch = '0;
    mst_awready = 1'b0; mst_wready = 1'b0;
    awr_mode = 0; wr_mode = 0; w_prob = 100; wr_pat_idx = 0;
    ph = 0; own = 0; burst_beat = 0; exp_err = 1'b0;
    n_aw_en = 0; n_whs = 0; st_early = 0; err_beat = -1; cyc = 0;
    for (int s = 0; s < N; s++) begin
      aw_seq[s] = 0; w_seq[s] = 0; w_beat[s] = 0; aw_hold[s] = 0; w_up[s] = 1'b0;
    end
    repeat (3) @(negedge aclk);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_overrun, 0);
    chk("rst_awvalid", mst_awvalid, 0);
    chk("rst_wvalid", mst_wvalid, 0);
    chk("rst_arb_en", arb_en, 0);
    arst = 1'b0;
    step();

    // single request from slave 2, 4 beats
    n_aw_en = 0; n_whs = 0;
    add_burst(2, 4);
    drain(100, "t1");
    chk("t1_arb_en_pulses", n_aw_en, 1);
    chk("t1_beats", n_whs, 4);
    chk("t1_owner", aw_own[aw_own.size()-1], 2);

    // all slaves requesting, single-beat bursts, round-robin from 0
    arst_pulse();
    aw_cyc.delete(); aw_own.delete();
    for (int r = 0; r < 2; r++) for (int s = 0; s < N; s++) add_burst(s, 1);
    drain(200, "t2");
    for (int i = 0; i < 5; i++) chk($sformatf("t2_order%0d", i), aw_own[i], i % N);
    for (int i = 0; i < 4; i++) chk($sformatf("t2_spacing%0d", i), aw_cyc[i+1] - aw_cyc[i], 3);

    // W beats offered two cycles before the AW
    n_whs = 0; st_early = 0;
    aw_hold[1] = 2;
    add_burst(1, 2);
    drain(100, "t3");
    chk("t3_early_w_cycles", st_early, 2);
    chk("t3_beats", n_whs, 2);

    // master W backpressure 1,0,0,1 over an 8-beat burst (also exceeds MAX_BEATS)
    n_whs = 0; wr_mode = 2; wr_pat_idx = 0;
    add_burst(0, 8);
    drain(200, "t4");
    chk("t4_beats", n_whs, 8);
    chk("t4_err", err_overrun, 1);
    wr_mode = 0;
    do_srst = 1'b1; step(); do_srst = 1'b0;
    step();
    chk("t4_err_cleared", err_overrun, 0);

    // overrun: slave 3, 6 beats
    n_whs = 0; err_beat = -1;
    add_burst(3, 6);
    drain(100, "t5");
    chk("t5_err_after_beat", err_beat, 4);
    chk("t5_beats", n_whs, 6);
    repeat (3) step();
    chk("t5_err_holds", err_overrun, 1);
    do_srst = 1'b1; step(); do_srst = 1'b0;
    step();
    chk("t5_err_srst", err_overrun, 0);

    // async reset mid-burst, then a normal transfer
    wr_mode = 1;
    add_burst(0, 8);
    begin
      int n = 0;
      while (!(ph == 2 && burst_beat >= 2) && n < 200) begin step(); n++; end
      chk("t6_reach_data", n < 200, 1);
    end
    arst_pulse();
    aw_own.delete();
    add_burst(2, 2);
    drain(100, "t6");
    chk("t6_owner", aw_own.size() > 0 ? aw_own[0] : -1, 2);

    // random traffic with one sync reset in the middle
    awr_mode = 1; wr_mode = 1; w_prob = 60;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(9) == 0) begin
        int s = $urandom_range(N-1);
        if (aw_q[s].size() < 3) add_burst(s, $urandom_range(6, 1));
      end
      do_srst = (c == 200);
      step();
    end
    do_srst = 1'b0;
    drain(3000, "t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
